// File: rtl/tx_link_ctrl.sv
// JESD204B transmit link-state controller: CGS -> ILAS -> DATA sequencing plus error-report counting.
// Latency: all outputs registered, 1 cycle from input to output; no backpressure (status-driven, always accepts).
module tx_link_ctrl #(
    parameter int ILAS_MF   = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sync_n,
    input  logic                 i_sync_request_tx,
    input  logic                 i_err_reporting,
    input  logic                 i_lmfc_tick,
    input  logic                 i_err_cnt_clr,
    output logic [1:0]           o_state,
    output logic                 o_send_cgs,
    output logic                 o_send_ilas,
    output logic [3:0]           o_ilas_mf_idx,
    output logic                 o_send_data,
    output logic                 o_link_up,
    output logic                 o_err_pulse,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CGS  = 2'b01,
        ST_ILAS = 2'b10,
        ST_DATA = 2'b11
    } state_t;

    localparam logic [3:0]           MF_LAST = 4'(ILAS_MF - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] mf_idx;
    logic [3:0] mf_idx_nxt;
    logic       err_prev;
    logic       err_ev;

    always_comb begin
        state_nxt  = state;
        mf_idx_nxt = mf_idx;
        case (state)
            ST_IDLE: begin
                if (!i_sync_n) state_nxt = ST_CGS;
            end
            ST_CGS: begin
                // SYNC~ deasserting between ticks just waits for the next LMFC boundary
                if (i_sync_n && i_lmfc_tick) begin
                    state_nxt  = ST_ILAS;
                    mf_idx_nxt = 4'd0;
                end
            end
            ST_ILAS: begin
                if (i_sync_request_tx) begin
                    state_nxt  = ST_CGS;
                    mf_idx_nxt = 4'd0;
                end else if (i_lmfc_tick) begin
                    if (mf_idx == MF_LAST) begin
                        state_nxt  = ST_DATA;
                        mf_idx_nxt = 4'd0;
                    end else begin
                        mf_idx_nxt = mf_idx + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (i_sync_request_tx) state_nxt = ST_CGS;
            end
            default: begin
                state_nxt  = ST_IDLE;
                mf_idx_nxt = 4'd0;
            end
        endcase
    end

    // Judged on the current state, so an edge landing on DATA->CGS still counts
    assign err_ev = (state == ST_DATA) && i_err_reporting && !err_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mf_idx      <= 4'd0;
            err_prev    <= 1'b0;
            o_send_cgs  <= 1'b0;
            o_send_ilas <= 1'b0;
            o_send_data <= 1'b0;
            o_link_up   <= 1'b0;
            o_err_pulse <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            mf_idx      <= mf_idx_nxt;
            err_prev    <= i_err_reporting;
            o_send_cgs  <= (state_nxt == ST_CGS);
            o_send_ilas <= (state_nxt == ST_ILAS);
            o_send_data <= (state_nxt == ST_DATA);
            o_link_up   <= (state_nxt == ST_DATA);
            o_err_pulse <= err_ev;
            if (i_err_cnt_clr)
                o_err_cnt <= '0;
            else if (err_ev && (o_err_cnt != CNT_MAX))
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

    assign o_state       = state;
    assign o_ilas_mf_idx = mf_idx;

endmodule

// File: tb/tb_tx_link_ctrl.sv
module tb_tx_link_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_sync_n;
    logic       i_sync_request_tx;
    logic       i_err_reporting;
    logic       i_lmfc_tick;
    logic       i_err_cnt_clr;
    logic [1:0] o_state;
    logic       o_send_cgs;
    logic       o_send_ilas;
    logic [3:0] o_ilas_mf_idx;
    logic       o_send_data;
    logic       o_link_up;
    logic       o_err_pulse;
    logic [1:0] o_err_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tx_link_ctrl #(.ILAS_MF(4), .ERR_CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_sync_n(i_sync_n),
        .i_sync_request_tx(i_sync_request_tx), .i_err_reporting(i_err_reporting),
        .i_lmfc_tick(i_lmfc_tick), .i_err_cnt_clr(i_err_cnt_clr),
        .o_state(o_state), .o_send_cgs(o_send_cgs), .o_send_ilas(o_send_ilas),
        .o_ilas_mf_idx(o_ilas_mf_idx), .o_send_data(o_send_data), .o_link_up(o_link_up),
        .o_err_pulse(o_err_pulse), .o_err_cnt(o_err_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        i_lmfc_tick = 1'b1;
        step();
        i_lmfc_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_sync_n = 1'b0; i_sync_request_tx = 1'b0;
        i_err_reporting = 1'b0; i_lmfc_tick = 1'b0; i_err_cnt_clr = 1'b0;
        step(); step();
        tests++;
        if ({o_state, o_send_cgs, o_send_ilas, o_ilas_mf_idx, o_send_data, o_link_up, o_err_pulse, o_err_cnt} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: state=%0d cgs=%0b ilas=%0b idx=%0d data=%0b up=%0b pulse=%0b cnt=%0d, all 0 required",
                     o_state, o_send_cgs, o_send_ilas, o_ilas_mf_idx, o_send_data, o_link_up, o_err_pulse, o_err_cnt);
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (o_state !== 2'b01 || o_send_cgs !== 1'b1) begin
            fails++;
            $display("FAIL reset_to_cgs: state=%0d cgs=%0b, required state=1 cgs=1", o_state, o_send_cgs);
        end
    endtask

    task automatic test_cgs_to_ilas();
        tick(); tick();
        tests++;
        if (o_state !== 2'b01) begin
            fails++;
            $display("FAIL cgs_ticks_sync_low: state=%0d, required 1", o_state);
        end
        i_sync_n = 1'b1;
        step();
        tests++;
        if (o_state !== 2'b01) begin
            fails++;
            $display("FAIL cgs_wait_tick: state=%0d, required 1", o_state);
        end
        tick();
        tests++;
        if (o_state !== 2'b10 || o_send_ilas !== 1'b1 || o_send_cgs !== 1'b0 || o_ilas_mf_idx !== 4'd0) begin
            fails++;
            $display("FAIL ilas_entry: state=%0d ilas=%0b cgs=%0b idx=%0d, required state=2 ilas=1 cgs=0 idx=0",
                     o_state, o_send_ilas, o_send_cgs, o_ilas_mf_idx);
        end
    endtask

    task automatic test_ilas_to_data();
        step();
        tests++;
        if (o_ilas_mf_idx !== 4'd0 || o_state !== 2'b10) begin
            fails++;
            $display("FAIL ilas_hold: state=%0d idx=%0d, required state=2 idx=0", o_state, o_ilas_mf_idx);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests++;
            if (o_state !== 2'b10 || o_ilas_mf_idx !== 4'(i)) begin
                fails++;
                $display("FAIL ilas_idx_%0d: state=%0d idx=%0d, required state=2 idx=%0d", i, o_state, o_ilas_mf_idx, i);
            end
        end
        tick();
        tests++;
        if (o_state !== 2'b11 || o_link_up !== 1'b1 || o_send_data !== 1'b1 || o_send_ilas !== 1'b0 || o_ilas_mf_idx !== 4'd0) begin
            fails++;
            $display("FAIL data_entry: state=%0d up=%0b data=%0b ilas=%0b idx=%0d, required 3 1 1 0 0",
                     o_state, o_link_up, o_send_data, o_send_ilas, o_ilas_mf_idx);
        end
    endtask

    task automatic test_err_report();
        i_err_reporting = 1'b1;
        step();
        tests++;
        if (o_err_pulse !== 1'b1 || o_err_cnt !== 2'd1 || o_state !== 2'b11) begin
            fails++;
            $display("FAIL err_first: pulse=%0b cnt=%0d state=%0d, required 1 1 3", o_err_pulse, o_err_cnt, o_state);
        end
        step();
        tests++;
        if (o_err_pulse !== 1'b0 || o_err_cnt !== 2'd1) begin
            fails++;
            $display("FAIL err_pulse_width: pulse=%0b cnt=%0d, required 0 1", o_err_pulse, o_err_cnt);
        end
        i_err_reporting = 1'b0;
        step();
        tests++;
        if (o_state !== 2'b11 || o_link_up !== 1'b1 || o_err_cnt !== 2'd1) begin
            fails++;
            $display("FAIL err_stay_data: state=%0d up=%0b cnt=%0d, required 3 1 1", o_state, o_link_up, o_err_cnt);
        end
    endtask

    task automatic test_resync();
        i_sync_request_tx = 1'b1; i_sync_n = 1'b0;
        step();
        tests++;
        if (o_state !== 2'b01 || o_send_data !== 1'b0 || o_send_cgs !== 1'b1 || o_link_up !== 1'b0) begin
            fails++;
            $display("FAIL resync_cgs: state=%0d data=%0b cgs=%0b up=%0b, required 1 0 1 0",
                     o_state, o_send_data, o_send_cgs, o_link_up);
        end
        i_sync_request_tx = 1'b0; i_sync_n = 1'b1;
        step();
        tick();
        tests++;
        if (o_state !== 2'b10 || o_ilas_mf_idx !== 4'd0) begin
            fails++;
            $display("FAIL resync_ilas: state=%0d idx=%0d, required 2 0", o_state, o_ilas_mf_idx);
        end
        // Re-init request beats a coincident tick during ILAS
        tick();
        i_sync_request_tx = 1'b1;
        tick();
        i_sync_request_tx = 1'b0;
        tests++;
        if (o_state !== 2'b01 || o_ilas_mf_idx !== 4'd0) begin
            fails++;
            $display("FAIL ilas_request_prio: state=%0d idx=%0d, required 1 0", o_state, o_ilas_mf_idx);
        end
        tick();
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (o_state !== 2'b11) begin
            fails++;
            $display("FAIL back_to_data: state=%0d, required 3", o_state);
        end
    endtask

    task automatic test_err_sat();
        int exp_cnt;
        i_err_cnt_clr = 1'b1;
        step();
        i_err_cnt_clr = 1'b0;
        tests++;
        if (o_err_cnt !== 2'd0) begin
            fails++;
            $display("FAIL err_clr: cnt=%0d, required 0", o_err_cnt);
        end
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            i_err_reporting = 1'b1;
            step();
            if (exp_cnt < 3) exp_cnt++;
            tests++;
            if (o_err_pulse !== 1'b1 || o_err_cnt !== 2'(exp_cnt)) begin
                fails++;
                $display("FAIL err_sat_%0d: pulse=%0b cnt=%0d, required 1 %0d", i, o_err_pulse, o_err_cnt, exp_cnt);
            end
            i_err_reporting = 1'b0;
            step();
        end
        i_err_reporting = 1'b1; i_err_cnt_clr = 1'b1;
        step();
        i_err_reporting = 1'b0; i_err_cnt_clr = 1'b0;
        tests++;
        if (o_err_cnt !== 2'd0 || o_err_pulse !== 1'b1) begin
            fails++;
            $display("FAIL err_clr_wins: cnt=%0d pulse=%0b, required 0 1", o_err_cnt, o_err_pulse);
        end
        step();
        i_err_reporting = 1'b1; i_sync_request_tx = 1'b1; i_sync_n = 1'b0;
        step();
        i_err_reporting = 1'b0; i_sync_request_tx = 1'b0;
        tests++;
        if (o_state !== 2'b01 || o_err_pulse !== 1'b1 || o_err_cnt !== 2'd1) begin
            fails++;
            $display("FAIL err_on_exit: state=%0d pulse=%0b cnt=%0d, required 1 1 1", o_state, o_err_pulse, o_err_cnt);
        end
        step();
        i_err_reporting = 1'b1;
        step();
        i_err_reporting = 1'b0;
        tests++;
        if (o_err_pulse !== 1'b0 || o_err_cnt !== 2'd1) begin
            fails++;
            $display("FAIL err_ignored_cgs: pulse=%0b cnt=%0d, required 0 1", o_err_pulse, o_err_cnt);
        end
    endtask

    task automatic test_reset_mid_ilas();
        i_sync_n = 1'b1;
        tick(); tick(); tick();
        tests++;
        if (o_state !== 2'b10 || o_ilas_mf_idx !== 4'd2) begin
            fails++;
            $display("FAIL pre_reset_ilas: state=%0d idx=%0d, required 2 2", o_state, o_ilas_mf_idx);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests++;
        if ({o_state, o_send_cgs, o_send_ilas, o_ilas_mf_idx, o_send_data, o_link_up, o_err_pulse, o_err_cnt} !== 13'd0) begin
            fails++;
            $display("FAIL reset_mid_ilas: state=%0d cgs=%0b ilas=%0b idx=%0d data=%0b up=%0b pulse=%0b cnt=%0d, all 0 required",
                     o_state, o_send_cgs, o_send_ilas, o_ilas_mf_idx, o_send_data, o_link_up, o_err_pulse, o_err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_cgs_to_ilas();
        test_ilas_to_data();
        test_err_report();
        test_resync();
        test_err_sat();
        test_reset_mid_ilas();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
